// File: rtl/op_button_encoder.sv
// Operator-button front end: synchronises and debounces the four raw operator
// buttons, rejects chords, and presents a held one-hot op code with strobes.
module op_button_encoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_add,
    input  logic       btn_sub,
    input  logic       btn_mul,
    input  logic       btn_div,
    input  logic       op_clear,
    output logic [3:0] op_code,
    output logic       op_valid,
    output logic       multi_err,
    output logic       busy
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] DEBOUNCE = 2'd1;
    localparam logic [1:0] HELD     = 2'd2;
    localparam logic [1:0] RELEASE  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       bundle;
    logic [3:0]       cand;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             cand_onehot;

    // Two-flop synchroniser per button; the raw inputs are fully asynchronous.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {btn_div, btn_mul, btn_sub, btn_add};
            sync2 <= sync1;
        end
    end

    assign bundle      = sync2;
    assign cand_onehot = (cand != 4'b0000) && ((cand & (cand - 4'd1)) == 4'b0000);
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cand      <= '0;
            op_code   <= '0;
            op_valid  <= 1'b0;
            multi_err <= 1'b0;
        end else begin
            op_valid  <= 1'b0;
            multi_err <= 1'b0;
            // NOTE: non-blocking assignments let a later op_code write in the
            // same edge (an accept) override this clear; the last one wins.
            if (op_clear) begin
                op_code <= '0;
            end

            case (state)
                IDLE: begin
                    if (bundle != 4'b0000) begin
                        cand  <= bundle;
                        cnt   <= '0;
                        state <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (bundle == 4'b0000) begin
                        state <= IDLE;
                    end else if (bundle != cand) begin
                        cand <= bundle;
                        cnt  <= '0;
                    end else if (cnt == CNT_LAST) begin
                        if (cand_onehot) begin
                            op_code  <= cand;
                            op_valid <= 1'b1;
                        end else begin
                            multi_err <= 1'b1;
                        end
                        state <= HELD;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HELD: begin
                    // Nothing new is accepted until every button is released.
                    if (bundle == 4'b0000) begin
                        cnt   <= '0;
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (bundle != 4'b0000) begin
                        state <= HELD;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_op_button_encoder.sv
// Self-checking bench for op_button_encoder: a run-length reference model is
// compared against the DUT after every clock edge, plus directed literal checks.
module tb_op_button_encoder;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_add = 1'b0;
    logic       btn_sub = 1'b0;
    logic       btn_mul = 1'b0;
    logic       btn_div = 1'b0;
    logic       op_clear = 1'b0;
    logic [3:0] op_code;
    logic       op_valid;
    logic       multi_err;
    logic       busy;

    always #5 clk = ~clk;

    op_button_encoder #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_add  (btn_add),
        .btn_sub  (btn_sub),
        .btn_mul  (btn_mul),
        .btn_div  (btn_div),
        .op_clear (op_clear),
        .op_code  (op_code),
        .op_valid (op_valid),
        .multi_err(multi_err),
        .busy     (busy)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: raw samples delayed two edges, then run-length rules.
    // "armed" = no press accepted yet; run counts consecutive identical
    // nonzero samples. Once latched, zrun counts consecutive released samples.
    logic [3:0] d1, d2, prev_b, m_code;
    bit         latched, m_valid, m_err;
    int         run, zrun;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_btn(input logic [3:0] v);
        {btn_div, btn_mul, btn_sub, btn_add} = v;
    endtask

    task automatic model_reset();
        d1 = '0; d2 = '0; prev_b = '0; m_code = '0;
        latched = 0; m_valid = 0; m_err = 0; run = 0; zrun = 0;
    endtask

    function automatic bit model_idle();
        return !latched && run == 0;
    endfunction

    function automatic bit will_accept();
        return !latched && d2 != 4'b0000 && run == D && d2 == prev_b;
    endfunction

    task automatic model_edge();
        logic [3:0] b;
        logic [3:0] nc;
        b = d2;
        nc = op_clear ? 4'b0000 : m_code;
        m_valid = 0;
        m_err = 0;
        if (!latched) begin
            if (b == 4'b0000) run = 0;
            else if (run > 0 && b == prev_b) run++;
            else run = 1;
            prev_b = b;
            if (run == D + 1) begin
                latched = 1;
                zrun = 0;
                run = 0;
                if ($countones(b) == 1) begin
                    nc = b;
                    m_valid = 1;
                end else begin
                    m_err = 1;
                end
            end
        end else begin
            zrun = (b == 4'b0000) ? zrun + 1 : 0;
            if (zrun == D + 1) begin
                latched = 0;
                run = 0;
            end
        end
        m_code = nc;
        d2 = d1;
        d1 = {btn_div, btn_mul, btn_sub, btn_add};
    endtask

    task automatic compare();
        check("op_code", int'(op_code), int'(m_code));
        check("op_valid", int'(op_valid), int'(m_valid));
        check("multi_err", int'(multi_err), int'(m_err));
        check("busy", int'(busy), int'(!model_idle()));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    // Asynchronous reset pulse placed between edges; released on the falling edge.
    task automatic pulse_reset();
        reset = 1'b0;
        model_reset();
        #1;
        compare();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic drain();
        set_btn(4'b0000);
        op_clear = 1'b0;
        for (int i = 0; i < 40 && !model_idle(); i++) step();
        check("drain_idle", int'(busy), 0);
    endtask

    int vcnt, ecnt, first, n;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #1;
        compare();
        check("reset_code", int'(op_code), 0);
        @(negedge clk);
        reset = 1'b1;

        // Clean multiply press: strobe at edge 7, code survives release.
        set_btn(4'b0100);
        vcnt = 0; first = 0;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (op_valid) begin
                vcnt++;
                if (first == 0) first = e;
            end
        end
        check("mul_edge", first, 7);
        check("mul_pulses", vcnt, 1);
        check("mul_code", int'(op_code), 4);
        set_btn(4'b0000);
        n = 0;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (!busy) begin
                n = e;
                break;
            end
        end
        check("mul_release_edges", n, 7);
        check("mul_code_after", int'(op_code), 4);

        // Bouncing add press settles into exactly one accept.
        vcnt = 0;
        for (int i = 0; i < 6; i++) begin
            btn_add = (i % 2 == 0);
            step();
            vcnt += int'(op_valid);
        end
        check("bounce_no_strobe", vcnt, 0);
        btn_add = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            vcnt += int'(op_valid);
        end
        check("bounce_pulses", vcnt, 1);
        check("bounce_code", int'(op_code), 1);
        drain();

        // Chord of sub+div is rejected.
        set_btn(4'b1010);
        vcnt = 0; ecnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            vcnt += int'(op_valid);
            ecnt += int'(multi_err);
        end
        check("chord_err", ecnt, 1);
        check("chord_valid", vcnt, 0);
        check("chord_code", int'(op_code), 1);
        drain();

        // Extra button during HELD is ignored.
        set_btn(4'b0001);
        for (int i = 0; i < 10; i++) step();
        set_btn(4'b1001);
        vcnt = 0; ecnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            vcnt += int'(op_valid);
            ecnt += int'(multi_err);
        end
        set_btn(4'b0000);
        n = 0;
        for (int e = 1; e <= 20; e++) begin
            step();
            vcnt += int'(op_valid);
            ecnt += int'(multi_err);
            if (!busy) begin
                n = e;
                break;
            end
        end
        check("held_strobes", vcnt + ecnt, 0);
        check("held_code", int'(op_code), 1);
        check("held_release_edges", n, 7);

        // op_clear coinciding with the accept loses; alone it clears.
        set_btn(4'b1000);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            op_clear = will_accept();
            step();
            if (op_clear) begin
                n = 1;
                break;
            end
        end
        check("clear_accept_seen", n, 1);
        check("clear_accept_code", int'(op_code), 8);
        check("clear_accept_valid", int'(op_valid), 1);
        op_clear = 1'b1;
        step();
        check("clear_alone_code", int'(op_code), 0);
        op_clear = 1'b0;
        drain();

        // Reset mid-debounce (counter at 2), then a full new press is needed.
        set_btn(4'b0010);
        for (int i = 0; i < 5; i++) step();
        pulse_reset();
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_code", int'(op_code), 0);
        first = 0;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (op_valid) begin
                first = e;
                break;
            end
        end
        check("rst_repress_edge", first, 7);
        drain();

        // Randomised traffic: held patterns with bounce, clears and resets.
        begin
            logic [3:0] target;
            logic [3:0] v;
            int r;
            target = 4'b0000;
            for (int i = 0; i < 1500; i++) begin
                r = int'($urandom_range(0, 99));
                if (r < 8) begin
                    case ($urandom_range(0, 2))
                        0: target = 4'b0000;
                        1: target = 4'b0001 << $urandom_range(0, 3);
                        default: target = 4'($urandom_range(0, 15));
                    endcase
                end
                v = target;
                if ($urandom_range(0, 9) == 0) v = v ^ 4'($urandom_range(0, 15));
                set_btn(v);
                op_clear = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 299) == 0) pulse_reset();
                else step();
            end
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/op_button_encoder.md
Name: op_button_encoder

Overview:
- Front end that produces the 4-bit one-hot operation code consumed by the calculator's operation latch.
- Takes four raw, asynchronous, bouncing operator buttons (+, -, x, /) and synchronises and debounces them.
- Rejects chords (two or more buttons pressed together).
- Emits a clean one-hot op code, a one-cycle op_valid strobe and a multi-press error strobe.
- Sits between the board push-buttons and the operation-selection logic.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable sampled cycles required to accept a press or a release; must be >= 2.
- CNT_W, 8: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- btn_add  input  1  raw addition button, active-high, asynchronous.
- btn_sub  input  1  raw subtraction button.
- btn_mul  input  1  raw multiplication button.
- btn_div  input  1  raw division button.
- op_clear  input  1  synchronous request to drop the held op code to 4'b0000.
- op_code  output  4  held one-hot code: 0001 add, 0010 sub, 0100 mul, 1000 div, 0000 none.
- op_valid  output  1  one-cycle strobe on the cycle a new op_code is loaded.
- multi_err  output  1  one-cycle strobe when a debounced chord (more than one bit set) is rejected.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - op_code=0000, op_valid=0, multi_err=0, busy=0.
  - FSM=IDLE, counter=0, candidate=0000, both synchroniser stages=0.
  - Reset asserted mid-debounce or mid-hold aborts immediately. No strobe is emitted after release from reset until a full new press is debounced.
- Synchroniser:
  - Each button passes through a 2-flop synchroniser.
  - bundle = {div,mul,sub,add} taken from the second stage.
  - Bundle therefore lags the raw inputs by 2 edges.
- FSM states: IDLE, DEBOUNCE, HELD, RELEASE.
- IDLE:
  - bundle != 0 -> candidate<=bundle, cnt<=0, go to DEBOUNCE.
- DEBOUNCE:
  - bundle == 0 -> IDLE; nothing emitted.
  - bundle != candidate (nonzero) -> candidate<=bundle, cnt<=0; stay in DEBOUNCE.
  - bundle == candidate and cnt < DEBOUNCE_CYCLES-1 -> cnt<=cnt+1.
  - bundle == candidate and cnt == DEBOUNCE_CYCLES-1 -> accept:
    - candidate is one-hot: op_code<=candidate, op_valid=1 for one cycle.
    - otherwise: multi_err=1 for one cycle and op_code is unchanged.
    - Either way go to HELD.
- HELD:
  - No new code is accepted while any button is down; changing which buttons are held has no effect.
  - bundle == 0 -> cnt<=0, go to RELEASE.
- RELEASE:
  - bundle != 0 -> HELD (the press was bounce).
  - bundle == 0 for DEBOUNCE_CYCLES consecutive cycles -> IDLE, using the same counting rule as DEBOUNCE.
- Latency: a clean press whose raw level is first sampled at edge 1 gives op_valid high after edge 3+DEBOUNCE_CYCLES. With the default of 4, that is edge 7.
- op_code:
  - Holds its value until the next accepted one-hot press, op_clear, or reset.
  - It is never updated by a chord.
- op_clear:
  - Sets op_code<=0000 on the next edge and does not affect the FSM.
  - If op_clear is high on the same edge as an accept, the accept wins: op_code gets the new code and op_valid=1.
- op_valid and multi_err are mutually exclusive and never assert on two consecutive cycles.
- busy = (state != IDLE).

Test Plan:
- Reset, then hold btn_mul=1 cleanly for 20 cycles, then release -> op_valid pulses once at edge 7, op_code=0100 and stays 0100 after release; busy returns to 0 after the release debounce.
- btn_add toggles 1/0 every cycle for 6 cycles, then settles to 1 -> no strobe during the bounce; exactly one op_valid, op_code=0001, after 4 stable cycles.
- btn_sub and btn_div pressed together for 10 cycles -> multi_err pulses once; op_code keeps its previous value (0001 from the prior test); op_valid stays 0.
- Hold btn_add, then also press btn_div during HELD, then release both -> no strobe; op_code unchanged; FSM returns to IDLE only after 4 clean released cycles.
- Drive op_clear=1 on the same edge that accepts a btn_div press -> op_code=1000, op_valid=1. Then op_clear=1 alone -> op_code=0000 on the next edge.
- Assert reset=0 with cnt=2 during DEBOUNCE of btn_sub -> all outputs 0 immediately; after reset=1 with the button still held, a full 2+1+4 edge sequence is required before op_valid.
